addac_seq: RTL and testbench

Sequenced 4-bit multiply/divide unit built on an add/subtract accumulator. It accepts two operands and an opcode, then issues per-cycle accumulate commands until the result is ready. Multiply uses repeated addition. Divide uses repeated subtraction. It sits above the accumulator chain as its command source, and completes each operation with a start/busy/done handshake.

---
 rtl/addac_pkg.sv | 25 ++
 rtl/addac_acc.sv | 47 ++++
 rtl/addac_seq.sv | 175 +++++++++++++++++
 tb/tb_addac_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/addac_pkg.sv
// Shared types for the add/subtract sequencer: accumulator commands, FSM states, opcodes.
package addac_pkg;

    localparam int WIDTH = 4;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Encoded as {sel1,sel0} on the accumulator command bus.
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        LOAD = 2'b01,
        ADD  = 2'b10,
        SUB  = 2'b11
    } acc_cmd_t;

    // ST_ prefix keeps these literals distinct from the acc_cmd_t LOAD in this scope.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/addac_acc.sv
// WIDTH-bit accumulator driven by an acc_cmd_t; SUB is a restoring subtract that only
// commits when there is no borrow, so the caller can test-and-subtract in one cycle.
module addac_acc
    import addac_pkg::*;
#(
    parameter int WIDTH = addac_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  acc_cmd_t         cmd,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] acc,
    output logic             cout
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign sum  = {1'b0, acc_q} + {1'b0, d};
    assign diff = {1'b0, acc_q} - {1'b0, d};
    assign acc  = acc_q;

    // cout: carry for ADD, no-borrow for SUB.
    always_comb begin
        cout = 1'b0;
        case (cmd)
            ADD:     cout = sum[WIDTH];
            SUB:     cout = ~diff[WIDTH];
            default: cout = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            case (cmd)
                LOAD: acc_q <= d;
                ADD:  acc_q <= sum[WIDTH-1:0];
                SUB:  if (!diff[WIDTH]) acc_q <= diff[WIDTH-1:0];
                default: acc_q <= acc_q;
            endcase
        end
    end

endmodule

// File: rtl/addac_seq.sv
// Sequenced multiply (repeated add) / divide (repeated subtract) unit issuing per-cycle
// commands to addac_acc, with a start/busy/done handshake and registered results.
module addac_seq
    import addac_pkg::*;
#(
    parameter int WIDTH = addac_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
    output logic             ovf,
    output logic             err,
    output state_t           dbg_state
);

    // Handshake: start is sampled only in ST_IDLE (busy=0); the accepting edge captures
    // op/a/b, busy is high from then until the edge leaving ST_DONE, and done is high for
    // exactly the one cycle spent in ST_DONE, when result/rem/ovf/err are already valid.

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_int_q, ovf_int_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    acc_cmd_t         acc_cmd;
    logic [WIDTH-1:0] acc_din;
    logic [WIDTH-1:0] acc_val;
    logic             acc_cout;

    addac_acc #(.WIDTH(WIDTH)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (acc_cmd),
        .d     (acc_din),
        .acc   (acc_val),
        .cout  (acc_cout)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        count_d   = count_q;
        q_d       = q_q;
        ovf_int_d = ovf_int_q;
        result_d  = result_q;
        rem_d     = rem_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        acc_cmd   = HOLD;
        acc_din   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                q_d       = '0;
                ovf_int_d = 1'b0;
                acc_cmd   = LOAD;
                if (op_q == OP_MUL) begin
                    acc_din = '0;
                    count_d = b_q;
                    state_d = ST_RUN;
                end else begin
                    acc_din = a_q;
                    if (b_q == '0) begin
                        // Divide by zero finishes straight from LOAD with a fixed result.
                        state_d  = ST_DONE;
                        result_d = '1;
                        rem_d    = a_q;
                        ovf_d    = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (op_q == OP_MUL) begin
                    if (count_q != '0) begin
                        acc_cmd   = ADD;
                        acc_din   = a_q;
                        count_d   = count_q - ONE;
                        ovf_int_d = ovf_int_q | acc_cout;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = acc_val;
                        rem_d    = '0;
                        ovf_d    = ovf_int_q;
                        err_d    = 1'b0;
                    end
                end else begin
                    // The accumulator keeps its value on borrow, leaving the remainder in place.
                    acc_cmd = SUB;
                    acc_din = b_q;
                    if (acc_cout) begin
                        q_d = q_q + ONE;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = q_q;
                        rem_d    = acc_val;
                        ovf_d    = 1'b0;
                        err_d    = 1'b0;
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            count_q   <= '0;
            q_q       <= '0;
            ovf_int_q <= 1'b0;
            result_q  <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            count_q   <= count_d;
            q_q       <= q_d;
            ovf_int_q <= ovf_int_d;
            result_q  <= result_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign rem       = rem_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_addac_seq.sv
// Scoreboard bench for addac_seq: each started operation pushes its modelled result and
// latency; the collector pops and compares when done is seen.
module tb_addac_seq;
    import addac_pkg::*;

    localparam int W       = 4;
    localparam int MAX_LAT = 64;
    localparam int NO_GLITCH = -10;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op    = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, ovf, err;
    logic [W-1:0] result, rem;
    state_t       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    // {latency[7:0], err, ovf, rem[3:0], result[3:0]}
    logic [17:0] exp_q[$];

    addac_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rem       (rem),
        .ovf       (ovf),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] model(input logic o, input logic [3:0] x, input logic [3:0] y);
        int         p;
        logic [7:0] lat;
        logic [3:0] r, m;
        logic       e, v;
        if (!o) begin
            p   = int'(x) * int'(y);
            r   = 4'(p % 16);
            m   = 4'd0;
            v   = (p > 15);
            e   = 1'b0;
            lat = 8'(int'(y) + 2);
        end else if (y == 4'd0) begin
            r   = 4'hF;
            m   = x;
            v   = 1'b0;
            e   = 1'b1;
            lat = 8'd1;
        end else begin
            r   = x / y;
            m   = x % y;
            v   = 1'b0;
            e   = 1'b0;
            lat = 8'(int'(x / y) + 2);
        end
        return {lat, e, v, m, r};
    endfunction

    task automatic drive_start(input logic o, input logic [3:0] x, input logic [3:0] y, input bit hold);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(model(o, x, y));
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        // Scramble operands after acceptance; they must not matter.
        op = 1'($urandom_range(0, 1));
        a  = 4'($urandom_range(0, 15));
        b  = 4'($urandom_range(0, 15));
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int glitch_at, output int lat);
        bit busy_ok;
        busy_ok = 1'b1;
        lat = 0;
        while (!done && lat < MAX_LAT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (lat == glitch_at) begin
                start = 1'b1;
                op    = 1'b1;
                a     = 4'd9;
                b     = 4'd0;
            end else if (lat == glitch_at + 1) begin
                start = 1'b0;
            end
        end
        if (glitch_at != NO_GLITCH) start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_held", 32'(busy_ok), 32'd1);
    endtask

    task automatic collect(input int lat);
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("latency", 32'(lat), 32'(e[17:10]));
        chk("result", 32'(result), 32'(e[3:0]));
        chk("rem", 32'(rem), 32'(e[7:4]));
        chk("ovf", 32'(ovf), 32'(e[8]));
        chk("err", 32'(err), 32'(e[9]));
    endtask

    task automatic idle_after();
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic o, input logic [3:0] x, input logic [3:0] y);
        int lat;
        drive_start(o, x, y, 1'b0);
        wait_done(NO_GLITCH, lat);
        collect(lat);
        idle_after();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int lat;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_rem", 32'(rem), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;

        // Directed cases
        run_op(OP_MUL, 4'd3, 4'd4);
        run_op(OP_MUL, 4'd5, 4'd4);
        run_op(OP_MUL, 4'd7, 4'd0);
        run_op(OP_DIV, 4'd13, 4'd4);
        run_op(OP_DIV, 4'd2, 4'd7);
        run_op(OP_DIV, 4'd9, 4'd0);

        // start pulsed mid-RUN with different operands is ignored
        drive_start(OP_MUL, 4'd3, 4'd4, 1'b0);
        wait_done(2, lat);
        collect(lat);
        idle_after();

        // start held through DONE: next operation accepted once back in IDLE
        drive_start(OP_MUL, 4'd2, 4'd1, 1'b1);
        wait_done(NO_GLITCH, lat);
        collect(lat);
        op = OP_DIV;
        a  = 4'd13;
        b  = 4'd4;
        exp_q.push_back(model(OP_DIV, 4'd13, 4'd4));
        @(posedge clk);
        @(negedge clk);
        chk("held_idle_busy", 32'(busy), 32'd0);
        chk("held_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("held_accept_busy", 32'(busy), 32'd1);
        wait_done(NO_GLITCH, lat);
        collect(lat);
        idle_after();

        // Random operations
        for (int i = 0; i < 10; i++) begin
            run_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-RUN clears everything immediately
        run_op(OP_DIV, 4'd13, 4'd4);
        drive_start(OP_MUL, 4'd15, 4'd15, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_rem", 32'(rem), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        // The aborted multiply never completes.
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_DIV, 4'd8, 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
